inequality_monitor: RTL and testbench

- Parametrised, clocked successor to the combinational 4-bit inequality block.
- Classifies a WIDTH-bit sample stream against programmable low/high thresholds into one-hot {above, inside, below}.
- A region is committed only after DEBOUNCE consecutive agreeing samples. Committed region changes are counted.
- Sits between a sampled data source (ADC/counter) and status/interrupt logic.

---
 rtl/ineq_pkg.sv | 56 +++++
 rtl/ineq_classify.sv | 32 +++
 rtl/inequality_monitor.sv | 144 ++++++++++++++
 tb/tb_inequality_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ineq_pkg.sv
// Shared types and helpers for the inequality monitor: region encoding,
// FSM state and a width-agnostic three-way threshold compare.
package ineq_pkg;

  localparam int unsigned EXT_W = 64;

  localparam logic [2:0] REG_NONE   = 3'b000;
  localparam logic [2:0] REG_BELOW  = 3'b001;
  localparam logic [2:0] REG_INSIDE = 3'b010;
  localparam logic [2:0] REG_ABOVE  = 3'b100;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_BELOW,
    ST_INSIDE,
    ST_ABOVE
  } state_e;

  // Operands arrive already extended to EXT_W (sign- or zero-extended by caller).
  function automatic logic [2:0] classify(input logic [EXT_W-1:0] s,
                                          input logic [EXT_W-1:0] lo,
                                          input logic [EXT_W-1:0] hi,
                                          input logic             sgn);
    logic lt;
    logic gt;
    if (sgn) begin
      lt = $signed(s) < $signed(lo);
      gt = $signed(s) > $signed(hi);
    end else begin
      lt = s < lo;
      gt = s > hi;
    end
    if (lt) return REG_BELOW;
    if (gt) return REG_ABOVE;
    return REG_INSIDE;
  endfunction

  function automatic state_e region_to_state(input logic [2:0] r);
    case (r)
      REG_BELOW:  return ST_BELOW;
      REG_INSIDE: return ST_INSIDE;
      REG_ABOVE:  return ST_ABOVE;
      default:    return ST_INIT;
    endcase
  endfunction

  function automatic logic [2:0] state_to_region(input state_e s);
    case (s)
      ST_BELOW:  return REG_BELOW;
      ST_INSIDE: return REG_INSIDE;
      ST_ABOVE:  return REG_ABOVE;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ineq_classify.sv
// Combinational one-hot {above, inside, below} compare of a sample against
// a low/high threshold pair; also usable as the legacy 4-bit block.
module ineq_classify
  import ineq_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [2:0]       cls_c
);

  logic [EXT_W-1:0] s_x;
  logic [EXT_W-1:0] lo_x;
  logic [EXT_W-1:0] hi_x;

  always_comb begin
    if (SIGNED != 0) begin
      s_x  = EXT_W'($signed(sample));
      lo_x = EXT_W'($signed(lo));
      hi_x = EXT_W'($signed(hi));
    end else begin
      s_x  = EXT_W'(sample);
      lo_x = EXT_W'(lo);
      hi_x = EXT_W'(hi);
    end
    cls_c = classify(s_x, lo_x, hi_x, SIGNED != 0);
  end

endmodule

// File: rtl/inequality_monitor.sv
// Debounced threshold-region monitor: classifies a sample stream, commits a
// region after DEBOUNCE agreeing samples and counts committed changes.
module inequality_monitor
  import ineq_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      SIGNED   = 0,
  parameter int unsigned      DEBOUNCE = 2,
  parameter logic [WIDTH-1:0] LO_INIT  = WIDTH'(4),
  parameter logic [WIDTH-1:0] HI_INIT  = WIDTH'(10),
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_vld,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic             thr_load,
  input  logic             clr_cnt,
  output logic [2:0]       region,
  output logic             region_vld,
  output logic             region_chg,
  output logic [CNT_W-1:0] trans_cnt,
  output logic             cfg_err
);

  localparam int unsigned     RUN_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  state_e           cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [2:0]       region_q, region_d;
  logic             region_vld_q, region_vld_d;
  logic             region_chg_q, region_chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;

  logic [2:0]       cls_smp_c;
  logic [2:0]       cls_cfg_c;
  state_e           cls_st;
  logic             load_ok;

  ineq_classify #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cls_smp (
    .sample (sample),
    .lo     (lo_q),
    .hi     (hi_q),
    .cls_c  (cls_smp_c)
  );

  // thr_lo classified "above" the degenerate window [thr_hi, thr_hi] means thr_lo > thr_hi.
  ineq_classify #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cls_cfg (
    .sample (thr_lo),
    .lo     (thr_hi),
    .hi     (thr_hi),
    .cls_c  (cls_cfg_c)
  );

  assign cls_st  = region_to_state(cls_smp_c);
  assign load_ok = (cls_cfg_c != REG_ABOVE);

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    run_d        = run_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    region_vld_d = region_vld_q;
    region_chg_d = 1'b0;
    cnt_d        = cnt_q;
    cfg_err_d    = 1'b0;

    if (thr_load) begin
      // A sample coincident with a load is discarded; it never commits.
      if (load_ok) begin
        lo_d   = thr_lo;
        hi_d   = thr_hi;
        run_d  = '0;
        cand_d = ST_INIT;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (sample_vld) begin
      if (cls_st == state_q) begin
        run_d  = '0;
        cand_d = ST_INIT;
      end else begin
        if (cls_st == cand_q) begin
          run_d = run_q + RUN_W'(1);
        end else begin
          cand_d = cls_st;
          run_d  = RUN_W'(1);
        end
        if (run_d == RUN_W'(DEBOUNCE)) begin
          state_d      = cls_st;
          cand_d       = ST_INIT;
          run_d        = '0;
          region_chg_d = 1'b1;
          region_vld_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    if (clr_cnt) cnt_d = '0;
    region_d = state_to_region(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cand_q       <= ST_INIT;
      run_q        <= '0;
      lo_q         <= LO_INIT;
      hi_q         <= HI_INIT;
      region_q     <= REG_NONE;
      region_vld_q <= 1'b0;
      region_chg_q <= 1'b0;
      cnt_q        <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      run_q        <= run_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      region_q     <= region_d;
      region_vld_q <= region_vld_d;
      region_chg_q <= region_chg_d;
      cnt_q        <= cnt_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign region     = region_q;
  assign region_vld = region_vld_q;
  assign region_chg = region_chg_q;
  assign trans_cnt  = cnt_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_inequality_monitor.sv
// Bench for inequality_monitor: three configurations share one stimulus
// stream and are checked every cycle against an integer-level model.
module tb_inequality_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sample;
  logic       sample_vld;
  logic [3:0] thr_lo;
  logic [3:0] thr_hi;
  logic       thr_load;
  logic       clr_cnt;

  logic [2:0] a_region, b_region, c_region;
  logic       a_vld, b_vld, c_vld;
  logic       a_chg, b_chg, c_chg;
  logic       a_err, b_err, c_err;
  logic [7:0] a_cnt, c_cnt;
  logic [1:0] b_cnt;

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  always #5 clk = ~clk;

  // Default configuration.
  inequality_monitor u_a (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .thr_load(thr_load), .clr_cnt(clr_cnt),
    .region(a_region), .region_vld(a_vld), .region_chg(a_chg),
    .trans_cnt(a_cnt), .cfg_err(a_err)
  );

  // Narrow counter, no debounce.
  inequality_monitor #(.DEBOUNCE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .thr_load(thr_load), .clr_cnt(clr_cnt),
    .region(b_region), .region_vld(b_vld), .region_chg(b_chg),
    .trans_cnt(b_cnt), .cfg_err(b_err)
  );

  // Signed compare, window -2..3.
  inequality_monitor #(.SIGNED(1), .LO_INIT(4'hE), .HI_INIT(4'h3)) u_c (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_vld(sample_vld),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .thr_load(thr_load), .clr_cnt(clr_cnt),
    .region(c_region), .region_vld(c_vld), .region_chg(c_chg),
    .trans_cnt(c_cnt), .cfg_err(c_err)
  );

  // Region as int: 0 none, 1 below, 2 inside, 3 above.
  typedef struct packed {
    int lo; int hi; int st; int cand; int run; int cnt;
    int cmax; int deb; int lo0; int hi0;
    bit sgn; bit vld; bit chg; bit err;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic int sval(input int x, input bit sgn);
    return (sgn && x >= 8) ? x - 16 : x;
  endfunction

  function automatic int mclass(input mdl_t m, input int x);
    int v;
    v = sval(x, m.sgn);
    if (v < sval(m.lo, m.sgn)) return 1;
    if (v > sval(m.hi, m.sgn)) return 3;
    return 2;
  endfunction

  function automatic mdl_t mreset(input mdl_t m);
    mdl_t n;
    n = m;
    n.lo = m.lo0; n.hi = m.hi0;
    n.st = 0; n.cand = 0; n.run = 0; n.cnt = 0;
    n.vld = 1'b0; n.chg = 1'b0; n.err = 1'b0;
    return n;
  endfunction

  function automatic mdl_t mk(input int lo0, input int hi0, input bit sgn,
                              input int deb, input int cmax);
    mdl_t n;
    n = '0;
    n.lo0 = lo0; n.hi0 = hi0; n.sgn = sgn; n.deb = deb; n.cmax = cmax;
    return mreset(n);
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit rn, input int s,
                                 input bit sv, input int tlo, input int thi,
                                 input bit ld, input bit clr);
    mdl_t n;
    int   c;
    if (!rn) return mreset(m);
    n = m;
    n.chg = 1'b0;
    n.err = 1'b0;
    c = mclass(m, s);
    if (ld) begin
      if (sval(tlo, m.sgn) <= sval(thi, m.sgn)) begin
        n.lo = tlo; n.hi = thi; n.run = 0; n.cand = 0;
      end else begin
        n.err = 1'b1;
      end
    end else if (sv) begin
      if (c == m.st) begin
        n.run = 0; n.cand = 0;
      end else begin
        if (c == m.cand) n.run = m.run + 1;
        else begin n.cand = c; n.run = 1; end
        if (n.run == m.deb) begin
          n.st = c; n.run = 0; n.cand = 0;
          n.chg = 1'b1; n.vld = 1'b1;
          if (n.cnt < n.cmax) n.cnt = n.cnt + 1;
        end
      end
    end
    if (clr) n.cnt = 0;
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mstep(ma, rst_n, int'(sample), sample_vld, int'(thr_lo), int'(thr_hi), thr_load, clr_cnt);
    mb <= mstep(mb, rst_n, int'(sample), sample_vld, int'(thr_lo), int'(thr_hi), thr_load, clr_cnt);
    mc <= mstep(mc, rst_n, int'(sample), sample_vld, int'(thr_lo), int'(thr_hi), thr_load, clr_cnt);
  end

  task automatic chk(input string nm, input logic [2:0] r, input logic v,
                     input logic c, input int cnt, input logic e, input mdl_t m);
    int er;
    er = (m.st == 0) ? 0 : (1 << (m.st - 1));
    vectors++;
    if (int'(r) != er || v != m.vld || c != m.chg || cnt != m.cnt || e != m.err) begin
      miscompares++;
      $display("FAIL %s @%0t: got region=%b vld=%b chg=%b cnt=%0d err=%b, expected region=%0d vld=%b chg=%b cnt=%0d err=%b",
               nm, $time, r, v, c, cnt, e, er, m.vld, m.chg, m.cnt, m.err);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("u_a", a_region, a_vld, a_chg, int'(a_cnt), a_err, ma);
      chk("u_b", b_region, b_vld, b_chg, int'(b_cnt), b_err, mb);
      chk("u_c", c_region, c_vld, c_chg, int'(c_cnt), c_err, mc);
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input int s, input bit v, input bit ld, input int lo,
                       input int hi, input bit clr);
    sample     = 4'(s);
    sample_vld = v;
    thr_load   = ld;
    thr_lo     = 4'(lo);
    thr_hi     = 4'(hi);
    clr_cnt    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int s);
    drive(s, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    ma = mk(4, 10, 1'b0, 2, 255);
    mb = mk(4, 10, 1'b0, 1, 3);
    mc = mk(14, 3, 1'b1, 2, 255);
    rst_n = 1'b0;
    sample = '0; sample_vld = 1'b0; thr_lo = '0; thr_hi = '0;
    thr_load = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    lit("reset_region", int'(a_region), 0);
    lit("reset_vld", int'(a_vld), 0);
    lit("reset_cnt", int'(a_cnt), 0);
    rst_n = 1'b1;

    // First commit from INIT.
    smp(2);
    lit("first_no_commit", int'(a_region), 0);
    smp(2);
    lit("below_region", int'(a_region), 1);
    lit("below_vld", int'(a_vld), 1);
    lit("below_chg", int'(a_chg), 1);
    lit("below_cnt", int'(a_cnt), 1);

    // Threshold equality is inside.
    smp(4); smp(4);
    lit("lo_eq_inside", int'(a_region), 2);
    lit("lo_eq_cnt", int'(a_cnt), 2);
    smp(10); smp(10);
    lit("hi_eq_inside", int'(a_region), 2);
    lit("hi_eq_no_chg", int'(a_chg), 0);
    smp(11); smp(11);
    lit("above_region", int'(a_region), 4);
    lit("above_cnt", int'(a_cnt), 3);
    smp(7); smp(7);
    lit("back_inside", int'(a_region), 2);

    // Bounce then run with an idle gap.
    smp(11); smp(7); smp(11);
    drive(7, 1'b0, 1'b0, 0, 0, 1'b0);
    lit("bounce_hold", int'(a_region), 2);
    smp(11);
    lit("bounce_commit", int'(a_region), 4);
    lit("bounce_chg", int'(a_chg), 1);
    lit("bounce_cnt", int'(a_cnt), 5);

    // Rejected load.
    drive(0, 1'b0, 1'b1, 9, 3, 1'b0);
    lit("cfg_err_pulse", int'(a_err), 1);
    smp(10); smp(10);
    lit("thr_kept", int'(a_region), 2);
    lit("thr_kept_cnt", int'(a_cnt), 6);

    // Accepted load clears a run in progress.
    smp(11);
    drive(11, 1'b1, 1'b1, 0, 15, 1'b0);
    lit("load_ok_no_err", int'(a_err), 0);
    lit("load_no_commit", int'(a_region), 2);
    drive(0, 1'b0, 1'b1, 4, 10, 1'b0);
    smp(11);
    lit("run_cleared", int'(a_region), 2);
    smp(11);
    lit("recommit", int'(a_region), 4);
    lit("recommit_cnt", int'(a_cnt), 7);
    lit("b_saturated", int'(b_cnt), 3);

    // Clear coincident with a commit.
    smp(7);
    drive(7, 1'b1, 1'b0, 0, 0, 1'b1);
    lit("clr_cnt_a", int'(a_cnt), 0);
    lit("clr_chg_a", int'(a_chg), 1);
    lit("clr_region_a", int'(a_region), 2);
    lit("clr_cnt_b", int'(b_cnt), 0);

    // Signed window -2..3.
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b1, 14, 3, 1'b0);
    lit("signed_load_ok", int'(c_err), 0);
    lit("unsigned_load_rej", int'(a_err), 1);
    smp(15);
    lit("signed_pending", int'(c_region), 0);
    smp(15);
    lit("signed_inside", int'(c_region), 2);
    lit("signed_cnt", int'(c_cnt), 1);
    smp(8); smp(8);
    lit("signed_below", int'(c_region), 1);

    // Reset mid-run discards the candidate.
    smp(3);
    rst_n = 1'b0;
    drive(3, 1'b1, 1'b0, 0, 0, 1'b0);
    lit("rst_region", int'(c_region), 0);
    lit("rst_vld", int'(c_vld), 0);
    lit("rst_chg", int'(c_chg), 0);
    lit("rst_cnt", int'(c_cnt), 0);
    rst_n = 1'b1;
    smp(3);
    lit("rst_cand_gone", int'(c_region), 0);
    smp(3);
    lit("post_rst_commit", int'(c_region), 2);
    lit("post_rst_chg", int'(c_chg), 1);

    drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
